hist_sched: RTL and testbench
=============================

HIST_SCHED -- requirements
Module: hist_sched

Interface
REQ-001 Parameter PIXELS, default 76800, pixels per frame (320x240, 8-bit grey).
REQ-002 Parameter BINS, default 256, histogram bins; index width 8.
REQ-003 Parameter CNT_W, default 24, bin count width; out_data_o width = 8 + CNT_W = 32.
REQ-004 The interface SHALL consist of the following ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- start_i  in  1  frame start request; sampled only in IDLE.
- mem_rd_o  out  1  frame memory read strobe.
- mem_addr_o  out  17  frame memory pixel address.
- mem_data_i  in  8  pixel, valid exactly one cycle after mem_rd_o.
- eng_clr_o  out  1  one-cycle pulse that clears all engine bins.
- eng_valid_o  out  1  pixel offered to the histogram engine.
- eng_pix_o  out  8  offered pixel.
- eng_ready_i  in  1  engine accepts the pixel when valid and ready are both high.
- bin_rd_o  out  1  engine bin read strobe.
- bin_addr_o  out  8  bin index.
- bin_data_i  in  CNT_W  bin count, valid one cycle after bin_rd_o.
- out_valid_o  out  1  result word valid.
- out_data_o  out  32  {bin index[7:0], count[CNT_W-1:0]}.
- out_ready_i  in  1  downstream accepts on valid and ready.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when the last bin is accepted.

Function
REQ-005 The FSM SHALL have the states IDLE, CLEAR, FEED, FLUSH, DRAIN and DONE.
REQ-006 IDLE->CLEAR when start_i=1; eng_clr_o=1 for the single CLEAR cycle; CLEAR->FEED.
REQ-007 FEED SHALL issue reads at addresses 0..PIXELS-1 in order, at most one read per cycle.
REQ-008 FEED SHALL issue a read only when no fetched pixel is outstanding or the outstanding pixel is accepted in the same cycle; throughput is 1 pixel/cycle with eng_ready_i=1.
REQ-009 A fetched pixel SHALL be held in a one-entry register; eng_pix_o stays stable and eng_valid_o stays high until the pixel is accepted.
REQ-010 FEED->FLUSH after read PIXELS-1 is issued; FLUSH->DRAIN when the last pixel is accepted.
REQ-011 Exactly PIXELS pixels SHALL be offered per frame, with no pixel duplicated or dropped.
REQ-012 DRAIN SHALL read bins 0..BINS-1 in order and present each as one out_data_o word.
REQ-013 out_data_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-014 DRAIN->DONE on acceptance of bin BINS-1; done_o=1 in DONE; DONE->IDLE on the next cycle.
REQ-015 start_i SHALL be ignored in every state except IDLE.
REQ-016 Address and bin counters SHALL never wrap: reaching the terminal value ends the phase.
REQ-017 If eng_ready_i is held low indefinitely, the block SHALL stall in FEED/FLUSH with no timeout.

Reset
REQ-018 Assertion of rst_i SHALL force IDLE asynchronously, including mid-frame.
REQ-019 During reset all outputs SHALL be 0 and the holding register SHALL be invalid.
REQ-020 No partial result word SHALL be emitted after reset deasserts.

Configuration
REQ-021 With HIST_SCHED_PERF_EN defined, the block SHALL add the output perf_cycles_o (32 bits): cycles from CLEAR through DONE, saturating at 2^32-1, cleared on entry to CLEAR, held in IDLE.
REQ-022 Without HIST_SCHED_PERF_EN, the port and its counter SHALL be absent.

Structure
REQ-023 Package hist_pkg SHALL hold the FSM state enum, PIXELS, BINS, CNT_W and the address width constant (17).
REQ-024 The one-entry pixel holding register SHALL be the sub-module hist_skid.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Frame of all 0x00, eng_ready_i=1, out_ready_i=1 -> word 0 = {0x00, 76800}, words 1..255 zero count, one done_o pulse.
- Ramp pixel = addr mod 256 -> every bin count = 300, indices 0..255 in order.
- eng_ready_i random 50% -> same bins as with ready held high, exactly 76800 handshakes, eng_pix_o stable during stalls.
- out_ready_i low for 10 cycles at bin 7 -> word 7 held unchanged, no word skipped.
- rst_i low at pixel 40000 -> all outputs 0; a new start_i yields a correct full frame beginning with an eng_clr_o pulse.
- start_i pulsed during DRAIN -> ignored, no extra eng_clr_o; with HIST_SCHED_PERF_EN and no stalls, perf_cycles_o = 76800 + overhead, the overhead equal to the fixed value given in the design note.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared constants and FSM encoding for the frame histogram scheduler.
// Optional cycle counter is enabled with HIST_SCHED_PERF_EN (see hist_sched).
package hist_pkg;

  localparam int unsigned PIXELS = 32'd76800;
  localparam int unsigned BINS   = 32'd256;
  localparam int unsigned CNT_W  = 32'd24;
  localparam int unsigned ADDR_W = 32'd17;

  // Unstalled frame length is PIXELS + 2*BINS + 4 cycles: CLEAR, FLUSH and DONE take
  // one cycle each, FEED takes PIXELS, DRAIN takes two cycles per bin plus one.
  localparam int unsigned PERF_OVERHEAD = 32'd2 * BINS + 32'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/hist_skid.sv
// One-entry pixel holding stage: offers the pixel returning from memory at once and
// keeps it when the engine stalls, so unstalled feeding runs at one pixel per cycle.
module hist_skid (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       accept
);

  logic       hold_valid_r;
  logic [7:0] hold_data_r;

  // Held pixel has priority; otherwise the pixel returning this cycle is offered.
  always_comb begin
    valid = hold_valid_r | in_valid;
    if (hold_valid_r) begin
      data = hold_data_r;
    end else if (in_valid) begin
      data = in_data;
    end else begin
      data = 8'd0;
    end
    accept = valid & ready;
  end

  // Capture a returning pixel the engine refused; release the held one on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= 8'd0;
    end else if (hold_valid_r) begin
      if (ready) begin
        hold_valid_r <= 1'b0;
      end
    end else if (in_valid && !ready) begin
      hold_valid_r <= 1'b1;
      hold_data_r  <= in_data;
    end
  end

endmodule

// File: rtl/hist_sched.sv
// Frame histogram scheduler: clears the engine, streams one frame of pixels into it,
// then drains every bin as {index, count}. HIST_SCHED_PERF_EN adds perf_cycles_o.
module hist_sched #(
  parameter int unsigned PIXELS = hist_pkg::PIXELS,
  parameter int unsigned BINS   = hist_pkg::BINS,
  parameter int unsigned CNT_W  = hist_pkg::CNT_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  output logic                        mem_rd_o,
  output logic [hist_pkg::ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]                  mem_data_i,
  output logic                        eng_clr_o,
  output logic                        eng_valid_o,
  output logic [7:0]                  eng_pix_o,
  input  logic                        eng_ready_i,
  output logic                        bin_rd_o,
  output logic [7:0]                  bin_addr_o,
  input  logic [CNT_W-1:0]            bin_data_i,
  output logic                        out_valid_o,
  output logic [8+CNT_W-1:0]          out_data_o,
  input  logic                        out_ready_i,
  output logic                        busy_o,
  output logic                        done_o
`ifdef HIST_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_cycles_o
`endif
);
  import hist_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIXELS - 32'd1);
  localparam logic [7:0]        BIN_LAST  = 8'(BINS - 32'd1);

  state_t             state_r;
  logic [ADDR_W-1:0]  addr_r;
  logic               rd_pend_r;
  logic [7:0]         bin_r;
  logic [7:0]         rd_idx_r;
  logic               bins_issued_r;
  logic               bin_pend_r;
  logic               out_valid_r;
  logic [8+CNT_W-1:0] out_data_r;
  logic               busy_r;
  logic               clr_r;
  logic               done_r;
  logic               eng_valid_s;
  logic [7:0]         eng_pix_s;
  logic               accept_s;
  logic               mem_rd_s;
  logic               bin_rd_s;
  logic               last_word_s;

  hist_skid u_skid (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .in_valid (rd_pend_r),
    .in_data  (mem_data_i),
    .ready    (eng_ready_i),
    .valid    (eng_valid_s),
    .data     (eng_pix_s),
    .accept   (accept_s)
  );

  // A new read only when nothing is offered or the offered item leaves this cycle.
  always_comb begin
    if (state_r == FEED) begin
      mem_rd_s = !eng_valid_s || accept_s;
    end else begin
      mem_rd_s = 1'b0;
    end
    if (state_r == DRAIN) begin
      bin_rd_s = !bins_issued_r && !bin_pend_r && (!out_valid_r || out_ready_i);
    end else begin
      bin_rd_s = 1'b0;
    end
    last_word_s = out_valid_r && out_ready_i && (out_data_r[8+CNT_W-1 -: 8] == BIN_LAST);
  end

  // Phase sequencing, address/bin counters and the result word register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r       <= IDLE;
      addr_r        <= '0;
      rd_pend_r     <= 1'b0;
      bin_r         <= 8'd0;
      rd_idx_r      <= 8'd0;
      bins_issued_r <= 1'b0;
      bin_pend_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      busy_r        <= 1'b0;
      clr_r         <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      rd_pend_r  <= mem_rd_s;
      bin_pend_r <= bin_rd_s;
      clr_r      <= 1'b0;
      done_r     <= 1'b0;
      if (bin_rd_s) begin
        rd_idx_r <= bin_r;
      end
      if (bin_pend_r) begin
        out_valid_r <= 1'b1;
        out_data_r  <= {rd_idx_r, bin_data_i};
      end else if (out_valid_r && out_ready_i) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r       <= CLEAR;
            clr_r         <= 1'b1;
            busy_r        <= 1'b1;
            addr_r        <= '0;
            bin_r         <= 8'd0;
            bins_issued_r <= 1'b0;
          end
        end
        CLEAR: state_r <= FEED;
        FEED: begin
          if (mem_rd_s) begin
            if (addr_r == ADDR_LAST) begin
              state_r <= FLUSH;
            end else begin
              addr_r <= addr_r + ADDR_W'(1'b1);
            end
          end
        end
        FLUSH: begin
          if (accept_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (bin_rd_s) begin
            if (bin_r == BIN_LAST) begin
              bins_issued_r <= 1'b1;
            end else begin
              bin_r <= bin_r + 8'd1;
            end
          end
          if (last_word_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_o    = mem_rd_s;
  assign mem_addr_o  = addr_r;
  assign eng_clr_o   = clr_r;
  assign eng_valid_o = eng_valid_s;
  assign eng_pix_o   = eng_pix_s;
  assign bin_rd_o    = bin_rd_s;
  assign bin_addr_o  = bin_r;
  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;

`ifdef HIST_SCHED_PERF_EN
  logic [31:0] perf_r;

  // Frame cycle counter: zeroed as a frame starts, counts CLEAR..DONE, sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_r <= 32'd0;
    end else if (state_r == IDLE) begin
      if (start_i) begin
        perf_r <= 32'd0;
      end
    end else if (perf_r != 32'hFFFF_FFFF) begin
      perf_r <= perf_r + 32'd1;
    end
  end

  assign perf_cycles_o = perf_r;
`endif

endmodule

// File: tb/tb_hist_sched.sv
// Self-checking bench for hist_sched with a reduced frame size so a run stays short;
// memory and histogram engine are behavioural models, results go through a scoreboard.
module tb_hist_sched;

  localparam int PIX    = 1280;
  localparam int RAMP   = PIX / 256;
  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        mem_rd_o;
  logic [16:0] mem_addr_o;
  logic [7:0]  mem_data_i;
  logic        eng_clr_o;
  logic        eng_valid_o;
  logic [7:0]  eng_pix_o;
  logic        eng_ready_i;
  logic        bin_rd_o;
  logic [7:0]  bin_addr_o;
  logic [23:0] bin_data_i;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_ready_i;
  logic        busy_o;
  logic        done_o;
`ifdef HIST_SCHED_PERF_EN
  logic [31:0] perf_cycles_o;
`endif

  hist_sched #(.PIXELS(PIX), .BINS(256), .CNT_W(24)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mem_rd_o    (mem_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .eng_clr_o   (eng_clr_o),
    .eng_valid_o (eng_valid_o),
    .eng_pix_o   (eng_pix_o),
    .eng_ready_i (eng_ready_i),
    .bin_rd_o    (bin_rd_o),
    .bin_addr_o  (bin_addr_o),
    .bin_data_i  (bin_data_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef HIST_SCHED_PERF_EN
    ,
    .perf_cycles_o (perf_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;
    bit rand_eng;
    int stall_bin;
    bit poke;
    int cnt0;
    int cntn;
  } frame_vec_t;

  frame_vec_t  vecs[5];
  logic [31:0] exp_q[$];
  int          eng_bins[256];

  int total = 0, bad = 0;
  int cur_pat = 0;
  bit rand_eng = 1'b0, stall_armed = 1'b0, poke_armed = 1'b0, start_req = 1'b0;
  int stall_bin = -1, stall_left = 0;
  int clr_cnt, done_cnt, hs_cnt, order_err, hold_err, stall_seen, eng_stalls, pokes;
  bit eng_prev_stall = 1'b0, out_prev_stall = 1'b0;
  logic [7:0]  eng_prev_pix;
  logic [31:0] out_prev_data;

  function automatic logic [7:0] pix_of(input int pat, input int a);
    case (pat)
      0:       return 8'd0;
      default: return 8'(a % 256);
    endcase
  endfunction

  // Frame memory: data one cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_o) mem_data_i <= pix_of(cur_pat, int'(mem_addr_o));
    else          mem_data_i <= 8'($urandom);
  end

  // Histogram engine: clear, count accepted pixels, bin data one cycle after the strobe.
  always @(posedge clk) begin
    if (eng_clr_o) begin
      for (int i = 0; i < 256; i++) eng_bins[i] <= 0;
    end else if (eng_valid_o && eng_ready_i) begin
      eng_bins[eng_pix_o] <= eng_bins[eng_pix_o] + 1;
    end
    if (bin_rd_o) bin_data_i <= 24'(eng_bins[bin_addr_o]);
    else          bin_data_i <= 24'($urandom);
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check(name, {mem_rd_o, mem_addr_o, eng_clr_o, eng_valid_o, eng_pix_o, bin_rd_o, bin_addr_o,
                 out_valid_o, out_data_o, busy_o, done_o}, 96'd0);
`ifdef HIST_SCHED_PERF_EN
    check({name, "_perf"}, perf_cycles_o, 96'd0);
`endif
  endtask

  task automatic monitor();
    logic [31:0] exp;
    if (rst_i) begin
      if (eng_clr_o) clr_cnt++;
      if (done_o) done_cnt++;
      if (eng_prev_stall && (!eng_valid_o || eng_pix_o !== eng_prev_pix)) hold_err++;
      if (out_prev_stall && (!out_valid_o || out_data_o !== out_prev_data)) hold_err++;
      if (eng_valid_o && !eng_ready_i) eng_stalls++;
      if (out_valid_o && !out_ready_i && stall_bin >= 0 && out_data_o[31:24] == stall_bin[7:0]) stall_seen++;
      if (eng_valid_o && eng_ready_i) begin
        if (eng_pix_o !== pix_of(cur_pat, hs_cnt)) order_err++;
        hs_cnt++;
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL word: got unexpected %h expected none", out_data_o);
        end else begin
          exp = exp_q.pop_front();
          check("word", out_data_o, exp);
        end
      end
      eng_prev_stall = eng_valid_o && !eng_ready_i;
      eng_prev_pix   = eng_pix_o;
      out_prev_stall = out_valid_o && !out_ready_i;
      out_prev_data  = out_data_o;
    end else begin
      eng_prev_stall = 1'b0;
      out_prev_stall = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (stall_armed && stall_left == 0 && out_valid_o && out_data_o[31:24] == stall_bin[7:0]) begin
      stall_left  = 10;
      stall_armed = 1'b0;
    end
    if (stall_left > 0) begin
      out_ready_i = 1'b0;
      stall_left--;
    end else begin
      out_ready_i = 1'b1;
    end
    eng_ready_i = rand_eng ? 1'($urandom_range(0, 1)) : 1'b1;
    start_i   = start_req;
    start_req = 1'b0;
    if (poke_armed && out_valid_o) begin
      start_i    = 1'b1;
      poke_armed = 1'b0;
      pokes++;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic clear_counts();
    clr_cnt = 0; done_cnt = 0; hs_cnt = 0; order_err = 0; hold_err = 0;
    stall_seen = 0; eng_stalls = 0; pokes = 0;
  endtask

  task automatic run_frame(input frame_vec_t v);
    cur_pat     = v.pat;
    rand_eng    = v.rand_eng;
    stall_bin   = v.stall_bin;
    stall_armed = (v.stall_bin >= 0);
    poke_armed  = v.poke;
    clear_counts();
    for (int b = 0; b < 256; b++) exp_q.push_back({8'(b), 24'(b == 0 ? v.cnt0 : v.cntn)});
    start_req = 1'b1;
    for (int c = 0; c < BUDGET && done_cnt == 0; c++) step();
    step();
    step();
    check("done_pulses", done_cnt, 96'd1);
    check("clr_pulses", clr_cnt, 96'd1);
    check("handshakes", hs_cnt, PIX);
    check("pixel_order", order_err, 96'd0);
    check("held_stable", hold_err, 96'd0);
    check("words_left", exp_q.size(), 96'd0);
    check("busy_after", busy_o, 96'd0);
    if (v.rand_eng) check("eng_stalled", eng_stalls > 0, 96'd1);
    if (v.stall_bin >= 0) check("stall_hold_cycles", stall_seen, 96'd10);
    if (v.poke) begin
      check("poke_sent", pokes, 96'd1);
`ifdef HIST_SCHED_PERF_EN
      check("perf_cycles", perf_cycles_o, PIX + 516);
`endif
    end
    exp_q.delete();
    stall_bin = -1;
  endtask

  initial begin
    int idle_err;
    rst_i = 1'b0; start_i = 1'b0; eng_ready_i = 1'b1; out_ready_i = 1'b1;
    vecs[0] = '{pat: 0, rand_eng: 1'b0, stall_bin: -1, poke: 1'b0, cnt0: PIX,  cntn: 0};
    vecs[1] = '{pat: 1, rand_eng: 1'b0, stall_bin: -1, poke: 1'b0, cnt0: RAMP, cntn: RAMP};
    vecs[2] = '{pat: 1, rand_eng: 1'b1, stall_bin: -1, poke: 1'b0, cnt0: RAMP, cntn: RAMP};
    vecs[3] = '{pat: 1, rand_eng: 1'b0, stall_bin: 7,  poke: 1'b0, cnt0: RAMP, cntn: RAMP};
    vecs[4] = '{pat: 1, rand_eng: 1'b0, stall_bin: -1, poke: 1'b1, cnt0: RAMP, cntn: RAMP};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_outputs");
    rst_i = 1'b1;
    repeat (3) step();
    check("idle_busy", busy_o, 96'd0);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Abort a frame halfway through FEED, then rerun a full frame.
    cur_pat = 1; rand_eng = 1'b0; stall_bin = -1; stall_armed = 1'b0; poke_armed = 1'b0;
    clear_counts();
    start_req = 1'b1;
    for (int c = 0; c < BUDGET && hs_cnt < PIX / 2; c++) step();
    check("abort_point", hs_cnt, PIX / 2);
    #2 rst_i = 1'b0;
    #1 check_reset("reset_mid_frame");
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    idle_err = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid_o || busy_o || eng_valid_o || eng_clr_o) idle_err++;
    end
    check("quiet_after_reset", idle_err, 96'd0);
    run_frame(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
